// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the dp_ctrl sequencer and its datapath: flag widths,
// command/completion bit indices, state enumeration and decode helpers.
package dp_ctrl_pkg;

    localparam int CMD_FLAG_W = 6;
    localparam int INT_FLAG_W = 6;
    localparam int IDX_W      = 5;

    localparam int CMD_INIT = 0;
    localparam int CMD_READ = 1;
    localparam int CMD_AVG  = 2;
    localparam int CMD_COMP = 3;
    localparam int CMD_SORT = 4;
    localparam int CMD_OUT  = 5;

    localparam int INT_INIT = 0;
    localparam int INT_READ = 1;
    localparam int INT_AVG  = 2;
    localparam int INT_COMP = 3;
    localparam int INT_SORT = 4;
    localparam int INT_OUT  = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_READ,
        ST_AVG,
        ST_COMP,
        ST_NEXT,
        ST_SORT,
        ST_OUT,
        ST_DONE
    } state_t;

    function automatic logic [CMD_FLAG_W-1:0] cmd_decode(input state_t s);
        logic [CMD_FLAG_W-1:0] c;
        c = '0;
        case (s)
            ST_INIT: c[CMD_INIT] = 1'b1;
            ST_READ: c[CMD_READ] = 1'b1;
            ST_AVG:  c[CMD_AVG]  = 1'b1;
            ST_COMP: c[CMD_COMP] = 1'b1;
            ST_SORT: c[CMD_SORT] = 1'b1;
            ST_OUT:  c[CMD_OUT]  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Only the completion bit belonging to the current state is looked at.
    function automatic logic flag_match(input state_t s, input logic [INT_FLAG_W-1:0] f);
        logic m;
        m = 1'b0;
        case (s)
            ST_INIT: m = f[INT_INIT];
            ST_READ: m = f[INT_READ];
            ST_AVG:  m = f[INT_AVG];
            ST_COMP: m = f[INT_COMP];
            ST_SORT: m = f[INT_SORT];
            ST_OUT:  m = f[INT_OUT];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic is_cmd_state(input state_t s);
        return |cmd_decode(s);
    endfunction

endpackage

// File: rtl/dp_ctrl_if.sv
// Control/status bundle between the dp_ctrl sequencer (master) and the
// datapath plus run requester (slave).
interface dp_ctrl_if;
    import dp_ctrl_pkg::*;

    logic                  start;
    logic [INT_FLAG_W-1:0] int_flags;
    logic [CMD_FLAG_W-1:0] cmd_flags;
    logic                  cnt_rst;
    logic [IDX_W-1:0]      image_in_index;
    logic                  img_req;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, int_flags,
        output cmd_flags, cnt_rst, image_in_index, img_req, busy, done, err
    );

    modport slave (
        output start, int_flags,
        input  cmd_flags, cnt_rst, image_in_index, img_req, busy, done, err
    );

endinterface

// File: rtl/dp_ctrl.sv
// Run sequencer for the image datapath: INIT, then READ/AVG/COMP per image,
// then SORT and OUT. Optional per-state watchdog enabled by DP_CTRL_TIMEOUT_EN.
module dp_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int NUM_IMG     = 32,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic      clk,
    input  logic      reset,
    dp_ctrl_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMG - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [CMD_FLAG_W-1:0] r_cmd;
    logic                  r_img_req;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_ack;
    logic                  w_tmo;
    logic                  w_cnt_rst;

    assign w_ack = flag_match(r_state, bus.int_flags);

`ifdef DP_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Cycles spent in the current state; restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != TMO_W'(TIMEOUT_CYC)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo = is_cmd_state(r_state) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_err <= 1'b0;
        end
    end

    assign bus.err = r_err;
`else
    // Watchdog compiled out: states wait forever and err is constant 0.
    assign w_tmo   = 1'b0;
    assign bus.err = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_INIT;
                    w_idx_nxt   = '0;
                end
            end
            ST_INIT: if (w_ack) w_state_nxt = ST_READ;
            ST_READ: if (w_ack) w_state_nxt = ST_AVG;
            ST_AVG:  if (w_ack) w_state_nxt = ST_COMP;
            ST_COMP: if (w_ack) w_state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (r_idx >= LAST_IDX) begin
                    w_state_nxt = ST_SORT;
                end else begin
                    w_state_nxt = ST_READ;
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            ST_SORT: if (w_ack) w_state_nxt = ST_OUT;
            ST_OUT:  if (w_ack) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_tmo) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Clear pulse in the cycle whose closing edge enters a counting phase.
    assign w_cnt_rst = (w_state_nxt != r_state) &&
                       (w_state_nxt inside {ST_READ, ST_SORT, ST_OUT});

    // Outputs are decoded from the next state so they register with it (Moore).
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cmd     <= '0;
            r_img_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cmd     <= cmd_decode(w_state_nxt);
            r_img_req <= (w_state_nxt == ST_READ);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.cmd_flags      = r_cmd;
    assign bus.cnt_rst        = w_cnt_rst;
    assign bus.image_in_index = r_idx;
    assign bus.img_req        = r_img_req;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;

endmodule

// File: tb/tb_dp_ctrl.sv
// Scoreboard bench for dp_ctrl: a NUM_IMG=32 instance and a NUM_IMG=2 instance
// (TIMEOUT_CYC=50) driven by a latency-model datapath; directed run scenarios.
module tb_dp_ctrl;
    import dp_ctrl_pkg::*;

    localparam logic [5:0] C_INIT = 6'b000001;
    localparam logic [5:0] C_READ = 6'b000010;
    localparam logic [5:0] C_AVG  = 6'b000100;
    localparam logic [5:0] C_COMP = 6'b001000;
    localparam logic [5:0] C_SORT = 6'b010000;
    localparam logic [5:0] C_OUT  = 6'b100000;
    localparam int         WAIT_MAX = 20000;

    logic clk;
    logic reset;

    dp_ctrl_if bus0 ();
    dp_ctrl_if bus1 ();

    dp_ctrl #(.NUM_IMG(32), .TIMEOUT_CYC(20000)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dp_ctrl #(.NUM_IMG(2), .TIMEOUT_CYC(50)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    logic       start_r  [2];
    logic [5:0] int_r    [2];
    logic [5:0] cmd_w    [2];
    logic [4:0] idx_w    [2];
    logic       crst_w   [2];
    logic       img_w    [2];
    logic       busy_w   [2];
    logic       done_w   [2];
    logic       err_w    [2];
    logic [5:0] ack_mask [2];
    logic [5:0] noise    [2];
    int         read_lat [2];
    int         n_crst   [2];
    logic [4:0] max_idx  [2];
    logic [5:0] mon_prev [2];
    logic [15:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign bus0.start     = start_r[0];
    assign bus0.int_flags = int_r[0];
    assign bus1.start     = start_r[1];
    assign bus1.int_flags = int_r[1];

    assign cmd_w[0]  = bus0.cmd_flags;      assign cmd_w[1]  = bus1.cmd_flags;
    assign idx_w[0]  = bus0.image_in_index; assign idx_w[1]  = bus1.image_in_index;
    assign crst_w[0] = bus0.cnt_rst;        assign crst_w[1] = bus1.cnt_rst;
    assign img_w[0]  = bus0.img_req;        assign img_w[1]  = bus1.img_req;
    assign busy_w[0] = bus0.busy;           assign busy_w[1] = bus1.busy;
    assign done_w[0] = bus0.done;           assign done_w[1] = bus1.done;
    assign err_w[0]  = bus0.err;            assign err_w[1]  = bus1.err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ev_pack(input int k, input logic d, input logic b,
                                            input logic im, input logic [5:0] c,
                                            input logic [4:0] i);
        logic [31:0] kk;
        kk = k;
        return {1'b0, kk[0], d, b, im, c, i};
    endfunction

    function automatic logic [31:0] out_vec(input int k);
        return {16'h0, cmd_w[k], crst_w[k], idx_w[k], img_w[k], busy_w[k], done_w[k], err_w[k]};
    endfunction

    task automatic push_ev(input int k, input logic [5:0] c, input logic [4:0] i);
        exp_q.push_back(ev_pack(k, 1'b0, 1'b1, (c == C_READ), c, i));
    endtask

    task automatic push_run(input int k, input int n);
        push_ev(k, C_INIT, 5'd0);
        for (int i = 0; i < n; i++) begin
            push_ev(k, C_READ, 5'(i));
            push_ev(k, C_AVG,  5'(i));
            push_ev(k, C_COMP, 5'(i));
        end
        push_ev(k, C_SORT, 5'(n - 1));
        push_ev(k, C_OUT,  5'(n - 1));
        exp_q.push_back(ev_pack(k, 1'b1, 1'b1, 1'b0, 6'h0, 5'(n - 1)));
    endtask

    task automatic pulse_start(input int k);
        start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
    endtask

    task automatic wait_cmd(input int k, input logic [5:0] c, input logic [4:0] i, input string name);
        int n;
        n = 0;
        while (!(cmd_w[k] == c && idx_w[k] == i) && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < WAIT_MAX), 32'd1);
    endtask

    task automatic wait_done(input int k, input string name);
        int n;
        n = 0;
        while (!done_w[k] && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < WAIT_MAX), 32'd1);
    endtask

    // Datapath model: acknowledges each command after 3 cycles (READ after read_lat).
    initial begin
        logic [5:0] mcmd [2];
        int         mcnt [2];
        int         lat;
        logic [5:0] drv;
        mcmd  = '{6'h0, 6'h0};
        mcnt  = '{0, 0};
        int_r = '{6'h0, 6'h0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (cmd_w[k] != mcmd[k]) mcnt[k] = 0;
                mcmd[k] = cmd_w[k];
                if (cmd_w[k] != 6'h0) mcnt[k]++;
                lat = (cmd_w[k] == C_READ) ? read_lat[k] : 3;
                drv = (cmd_w[k] != 6'h0 && mcnt[k] >= lat) ? (cmd_w[k] & ack_mask[k]) : 6'h0;
                int_r[k] = drv | ((cmd_w[k] == C_AVG) ? noise[k] : 6'h0);
            end
        end
    end

    // Monitor: every new command or done pulse is popped from the scoreboard.
    initial begin
        logic [15:0] act;
        logic [15:0] exp;
        mon_prev = '{6'h0, 6'h0};
        n_crst   = '{0, 0};
        max_idx  = '{5'd0, 5'd0};
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 2; k++) begin
                if (crst_w[k]) n_crst[k]++;
                if (idx_w[k] > max_idx[k]) max_idx[k] = idx_w[k];
                if (done_w[k] || (cmd_w[k] != mon_prev[k] && cmd_w[k] != 6'h0)) begin
                    act = ev_pack(k, done_w[k], busy_w[k], img_w[k], cmd_w[k], idx_w[k]);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected_event: got 0x%0h with nothing expected", act);
                    end else begin
                        exp = exp_q.pop_front();
                        check($sformatf("sb_event_dut%0d", k), 32'(act), 32'(exp));
                    end
                end
                mon_prev[k] = cmd_w[k];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        start_r  = '{1'b0, 1'b0};
        ack_mask = '{6'h3F, 6'h3F};
        noise    = '{6'h0, 6'h0};
        read_lat = '{100, 20};
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_dut0", out_vec(0), 32'h0);
        check("reset_outputs_dut1", out_vec(1), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_no_cmd", out_vec(0), 32'h0);

        // Full run; start held 5 cycles, AVG hold with foreign flags, mid-run start.
        n_crst[0] = 0;
        push_run(0, 32);
        start_r[0] = 1'b1;
        @(negedge clk);
        check("start_latency", 32'(cmd_w[0]), 32'(C_INIT));
        repeat (4) @(negedge clk);
        start_r[0] = 1'b0;
        wait_cmd(0, C_AVG, 5'd5, "wait_avg5");
        ack_mask[0] = ~C_AVG;
        noise[0]    = ~C_AVG;
        repeat (10) @(negedge clk);
        check("avg_hold", {21'h0, cmd_w[0], idx_w[0]}, {21'h0, C_AVG, 5'd5});
        ack_mask[0] = 6'h3F;
        noise[0]    = 6'h0;
        wait_cmd(0, C_READ, 5'd9, "wait_read9");
        pulse_start(0);
        wait_done(0, "wait_done_run1");
        repeat (20) @(negedge clk);
        check("run1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("run1_cnt_rst_pulses", 32'(n_crst[0]), 32'd34);
        check("run1_max_index", 32'(max_idx[0]), 32'd31);
        check("run1_idle_busy", 32'(busy_w[0]), 32'd0);
        check("run1_err", 32'(err_w[0]), 32'd0);

        // Reset while reading image 7, then a fresh run from image 0.
        push_ev(0, C_INIT, 5'd0);
        for (int i = 0; i < 7; i++) begin
            push_ev(0, C_READ, 5'(i));
            push_ev(0, C_AVG,  5'(i));
            push_ev(0, C_COMP, 5'(i));
        end
        push_ev(0, C_READ, 5'd7);
        pulse_start(0);
        wait_cmd(0, C_READ, 5'd7, "wait_read7");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_outputs", out_vec(0), 32'h0);
        check("midrun_queue_empty", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_no_cmd", 32'(cmd_w[0]), 32'h0);
        n_crst[0] = 0;
        push_run(0, 32);
        pulse_start(0);
        wait_done(0, "wait_done_run2");
        repeat (10) @(negedge clk);
        check("run2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("run2_cnt_rst_pulses", 32'(n_crst[0]), 32'd34);

        // NUM_IMG=2 instance.
        n_crst[1] = 0;
        push_run(1, 2);
        pulse_start(1);
        wait_done(1, "wait_done_small");
        repeat (10) @(negedge clk);
        check("small_queue_empty", 32'(exp_q.size()), 32'd0);
        check("small_cnt_rst_pulses", 32'(n_crst[1]), 32'd4);
        check("small_max_index", 32'(max_idx[1]), 32'd1);

`ifdef DP_CTRL_TIMEOUT_EN
        // READ never acknowledged: err at cycle 50 after READ entry, no done.
        ack_mask[1] = ~C_READ;
        push_ev(1, C_INIT, 5'd0);
        push_ev(1, C_READ, 5'd0);
        pulse_start(1);
        wait_cmd(1, C_READ, 5'd0, "wait_tmo_read");
        repeat (49) @(negedge clk);
        check("tmo_not_yet", {30'h0, err_w[1], busy_w[1]}, 32'b01);
        @(negedge clk);
        check("tmo_err_idle", {24'h0, cmd_w[1], busy_w[1], err_w[1]}, 32'b01);
        check("tmo_no_done", 32'(done_w[1]), 32'd0);
        ack_mask[1] = 6'h3F;
        repeat (5) @(negedge clk);
        push_run(1, 2);
        pulse_start(1);
        check("tmo_err_cleared", 32'(err_w[1]), 32'd0);
        wait_done(1, "wait_done_after_tmo");
        repeat (10) @(negedge clk);
        check("tmo_queue_empty", 32'(exp_q.size()), 32'd0);
`else
        check("no_wdog_err_dut1", 32'(err_w[1]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
